// File: rtl/cv32e40p_lcm_alarm_handler.sv
// Loop/basic-block length alarm handler: converts detector alarm edges into a
// req/ack fault request to the controller and escalates to a sticky lockdown
// after repeated alarms or an unacknowledged request.
module cv32e40p_lcm_alarm_handler #(
  parameter int unsigned ALARM_THRESHOLD = 3,
  parameter int unsigned ACK_TIMEOUT     = 16,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alarm_i,
  input  logic                 enable_i,
  input  logic                 ack_i,
  input  logic                 clear_i,
  output logic                 req_o,
  output logic                 lock_o,
  output logic                 pending_o,
  output logic [CNT_WIDTH-1:0] alarm_cnt_o
);

  localparam int unsigned ESC_W = $clog2(ALARM_THRESHOLD + 1);
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    SERVICED = 2'd2,
    LOCKED   = 2'd3
  } state_e;

  state_e           state_q;
  logic             alarm_q;
  logic [ESC_W-1:0] esc_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;

  logic             evt_c;
  logic [ESC_W-1:0] esc_nxt_c;
  logic             esc_hit_c;
  logic             tmo_hit_c;
  logic             cnt_sat_c;

  // Event detection and escalation arithmetic (clear takes effect before counting)
  always_comb begin
    evt_c     = alarm_i & ~alarm_q & enable_i;
    esc_nxt_c = clear_i ? ESC_W'(1) : esc_cnt_q + ESC_W'(1);
    esc_hit_c = (esc_nxt_c == ESC_W'(ALARM_THRESHOLD));
    tmo_hit_c = (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1));
    cnt_sat_c = (alarm_cnt_o == {CNT_WIDTH{1'b1}});
  end

  // Alarm edge register, FSM, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alarm_q     <= 1'b0;
      esc_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      req_o       <= 1'b0;
      lock_o      <= 1'b0;
      pending_o   <= 1'b0;
      alarm_cnt_o <= '0;
    end else begin
      alarm_q <= alarm_i;
      unique case (state_q)
        IDLE: begin
          if (evt_c) begin
            if (!cnt_sat_c) begin
              alarm_cnt_o <= alarm_cnt_o + CNT_WIDTH'(1);
            end
            esc_cnt_q <= esc_nxt_c;
            if (esc_hit_c) begin
              state_q <= LOCKED;
              lock_o  <= 1'b1;
            end else begin
              state_q   <= REQ;
              tmo_cnt_q <= '0;
              req_o     <= 1'b1;
              pending_o <= 1'b1;
            end
          end else if (clear_i) begin
            esc_cnt_q <= '0;
          end
        end
        REQ: begin
          if (clear_i) begin
            esc_cnt_q <= '0;
          end
          // Ack has priority over a timeout landing in the same cycle
          if (ack_i) begin
            state_q <= SERVICED;
            req_o   <= 1'b0;
          end else if (tmo_hit_c) begin
            state_q   <= LOCKED;
            req_o     <= 1'b0;
            pending_o <= 1'b0;
            lock_o    <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        SERVICED: begin
          if (clear_i) begin
            esc_cnt_q <= '0;
          end
          // Wait for the detector to re-arm before accepting new events
          if (!alarm_i) begin
            state_q   <= IDLE;
            pending_o <= 1'b0;
          end
        end
        LOCKED: begin
          state_q <= LOCKED;
        end
        default: begin
          state_q <= LOCKED;
          lock_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_lcm_alarm_handler.sv
// Scoreboard bench for the alarm handler: a default-parameter instance (a) and a
// narrow-counter instance (b) driven by directed per-cycle vectors.
module tb_cv32e40p_lcm_alarm_handler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_alarm, a_en, a_ack, a_clr;
  logic       a_req, a_lock, a_pend;
  logic [7:0] a_cnt;
  logic       b_alarm, b_en, b_ack, b_clr;
  logic       b_req, b_lock, b_pend;
  logic [1:0] b_cnt;

  cv32e40p_lcm_alarm_handler #(
    .ALARM_THRESHOLD(3), .ACK_TIMEOUT(16), .CNT_WIDTH(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .alarm_i(a_alarm), .enable_i(a_en), .ack_i(a_ack),
    .clear_i(a_clr), .req_o(a_req), .lock_o(a_lock), .pending_o(a_pend), .alarm_cnt_o(a_cnt)
  );

  cv32e40p_lcm_alarm_handler #(
    .ALARM_THRESHOLD(8), .ACK_TIMEOUT(16), .CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .alarm_i(b_alarm), .enable_i(b_en), .ack_i(b_ack),
    .clear_i(b_clr), .req_o(b_req), .lock_o(b_lock), .pending_o(b_pend), .alarm_cnt_o(b_cnt)
  );

  typedef struct {
    string name;
    bit    dut;
    bit    r;
    bit    l;
    bit    p;
    int    c;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic cmp(input exp_t e);
    if (!e.dut) begin
      chk({e.name, ".req"},  int'(a_req),  int'(e.r));
      chk({e.name, ".lock"}, int'(a_lock), int'(e.l));
      chk({e.name, ".pend"}, int'(a_pend), int'(e.p));
      chk({e.name, ".cnt"},  int'(a_cnt),  e.c);
    end else begin
      chk({e.name, ".req"},  int'(b_req),  int'(e.r));
      chk({e.name, ".lock"}, int'(b_lock), int'(e.l));
      chk({e.name, ".pend"}, int'(b_pend), int'(e.p));
      chk({e.name, ".cnt"},  int'(b_cnt),  e.c);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge after each active edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e);
    end
  end

  // One cycle of stimulus on instance a plus its expected post-edge outputs
  task automatic sa(input string nm, input bit al, input bit en, input bit ak, input bit cl,
                    input bit r, input bit l, input bit p, input int c);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    a_alarm = al; a_en = en; a_ack = ak; a_clr = cl;
    sb.push_back('{nm, 1'b0, r, l, p, c});
  endtask

  task automatic sb_step(input string nm, input bit al, input bit en, input bit ak, input bit cl,
                         input bit r, input bit l, input bit p, input int c);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    b_alarm = al; b_en = en; b_ack = ak; b_clr = cl;
    sb.push_back('{nm, 1'b1, r, l, p, c});
  endtask

  // Mid-cycle reset: outputs must drop without waiting for a clock edge
  task automatic do_reset(input string nm);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk({nm, ".req"},  int'(a_req),  0);
    chk({nm, ".lock"}, int'(a_lock), 0);
    chk({nm, ".pend"}, int'(a_pend), 0);
    chk({nm, ".cnt"},  int'(a_cnt),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    a_alarm = 0; a_en = 0; a_ack = 0; a_clr = 0;
    b_alarm = 0; b_en = 0; b_ack = 0; b_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",  int'(a_req),  0);
    chk("rst.lock", int'(a_lock), 0);
    chk("rst.pend", int'(a_pend), 0);
    chk("rst.cnt",  int'(a_cnt),  0);
    chk("rst.bcnt", int'(b_cnt),  0);

    // Basic request / ack / re-arm
    sa("t1_idle",        0,1,0,0, 0,0,0,0);
    sa("t1_rise",        1,1,0,0, 1,0,1,1);
    sa("t1_wait0",       1,1,0,0, 1,0,1,1);
    sa("t1_wait1",       1,1,0,0, 1,0,1,1);
    sa("t1_ack",         1,1,1,0, 0,0,1,1);
    sa("t1_svc_ack_ign", 1,1,1,0, 0,0,1,1);
    sa("t1_svc",         1,1,0,0, 0,0,1,1);
    sa("t1_rearm",       0,1,0,0, 0,0,0,1);
    sa("t1_idle2",       0,1,0,0, 0,0,0,1);
    // Second alarm, ack while alarm already low
    sa("t2_a2",          1,1,0,0, 1,0,1,2);
    sa("t2_ack2",        0,1,1,0, 0,0,1,2);
    sa("t2_idle2",       0,1,0,0, 0,0,0,2);
    sa("t2_ack_idle",    0,1,1,0, 0,0,0,2);
    // Clear between alarm 2 and 3 avoids the lock
    sa("t4_clear",       0,1,0,1, 0,0,0,2);
    sa("t4_a3",          1,1,0,0, 1,0,1,3);
    sa("t4_ack3",        0,1,1,0, 0,0,1,3);
    sa("t4_idle3",       0,1,0,0, 0,0,0,3);
    // Disabled rising edge is lost; re-enable while high makes no event
    sa("t4_dis_rise",    1,0,0,0, 0,0,0,3);
    sa("t4_dis_hold",    1,0,0,0, 0,0,0,3);
    sa("t4_reen_high",   1,1,0,0, 0,0,0,3);
    sa("t4_fall",        0,1,0,0, 0,0,0,3);
    sa("t4_a4",          1,1,0,0, 1,0,1,4);
    sa("t4_ack4",        0,1,1,0, 0,0,1,4);
    sa("t4_idle4",       0,1,0,0, 0,0,0,4);
    // Third alarm since clear locks with no request
    sa("t2_lock",        1,1,0,0, 0,1,0,5);
    sa("lk_ack_clr",     1,1,1,1, 0,1,0,5);
    sa("lk_fall",        0,1,0,1, 0,1,0,5);
    sa("lk_rise",        1,1,0,0, 0,1,0,5);

    // Reset in LOCKED, release with alarm held high
    do_reset("t6_rst_locked");
    sa("t6_rel_high",    1,1,0,0, 1,0,1,1);
    for (int i = 0; i < 15; i++) sa("t3_req", 1,1,0,0, 1,0,1,1);
    sa("t3_lock",        1,1,0,0, 0,1,0,1);
    sa("t3_lock_hold",   1,1,1,0, 0,1,0,1);

    // Reset mid-REQ
    do_reset("t6_rst_lock2");
    sa("t6_rel_low",     0,1,0,0, 0,0,0,0);
    sa("t6_rise",        1,1,0,0, 1,0,1,1);
    do_reset("t6_rst_req");
    sa("t3b_low",        0,1,0,0, 0,0,0,0);
    // Ack in the timeout cycle wins
    sa("t3b_rise",       1,1,0,0, 1,0,1,1);
    for (int i = 0; i < 15; i++) sa("t3b_req", 1,1,0,0, 1,0,1,1);
    sa("t3b_ack16",      1,1,1,0, 0,0,1,1);
    for (int i = 0; i < 3; i++) sa("t3b_svc", 1,1,0,0, 0,0,1,1);
    sa("t3b_rearm",      0,1,0,0, 0,0,0,1);
    // Clear and event together count as one
    sa("cl_evt",         1,1,0,1, 1,0,1,2);
    sa("cl_ack",         0,1,1,0, 0,0,1,2);
    sa("cl_idle",        0,1,0,0, 0,0,0,2);
    sa("e_a2",           1,1,0,0, 1,0,1,3);
    sa("e_ack2",         0,1,1,0, 0,0,1,3);
    sa("e_idle2",        0,1,0,0, 0,0,0,3);
    sa("e_a3_lock",      1,1,0,0, 0,1,0,4);

    // Saturating counter on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      c = (i + 1 > 3) ? 3 : i + 1;
      sb_step("t5_rise", 1,1,0,0, 1,0,1,c);
      sb_step("t5_ack",  0,1,1,1, 0,0,1,c);
      sb_step("t5_idle", 0,1,0,0, 0,0,0,c);
    end

    @(negedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
